load_store_unit: RTL and testbench

- Memory-access stage of the pipelined RV32I core.
- Consumes the effective address and load/store decode produced by the execute-stage ALU, plus the rs2 store data.
- Drives a req/gnt/rvalid data-memory port and returns aligned, sign- or zero-extended load data to writeback.
- Stalls the pipeline while a bus transaction is outstanding.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: req/gnt/rvalid data port, store packing, load extract/extend; LSU_MISALIGN_EN enables misalign trap.
// Latency: store 2 cycles start->done (gnt same cycle), load 3 cycles plus rvalid delay.
// Backpressure: holds req/addr/data until gnt; lsu_stall_o holds upstream while REQ/WAIT.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic [7:0]       load_store_info_i,
    input  logic [WIDTH-1:0] mem_addr_i,
    input  logic [WIDTH-1:0] store_data_i,
    input  logic             flush_i,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [WIDTH-1:0] dmem_addr_o,
    output logic [3:0]       dmem_wstrb_o,
    output logic [WIDTH-1:0] dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [WIDTH-1:0] dmem_rdata_i,
    output logic             lsu_stall_o,
    output logic             lsu_done_o,
    output logic [WIDTH-1:0] load_data_o,
    output logic             misalign_o
);

`ifdef LSU_MISALIGN_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
`endif

    typedef enum logic [2:0] {
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_t;

    state_t           state_q, state_d;
    op_t              op_dec, op_q;
    logic             store_dec;
    logic [3:0]       wstrb_dec;
    logic [WIDTH-1:0] wdata_dec;
    logic [1:0]       off_in;
    logic             start;

    logic [WIDTH-1:0] addr_q;
    logic [1:0]       off_q;
    logic             we_q;
    logic [3:0]       wstrb_q;
    logic [WIDTH-1:0] wdata_q;
    logic             killed_q;
    logic [WIDTH-1:0] load_data_q;
    logic [WIDTH-1:0] load_ext;
    logic [WIDTH-1:0] rshift;
    logic [15:0]      half_sel;

    assign off_in = mem_addr_i[1:0];
    assign start  = ex_valid_i & (|load_store_info_i) & (state_q == S_IDLE) & ~flush_i;

    // Highest-numbered decode bit wins when several are set.
    always_comb begin
        op_dec = OP_SW;
        if      (load_store_info_i[7]) op_dec = OP_LB;
        else if (load_store_info_i[6]) op_dec = OP_LH;
        else if (load_store_info_i[5]) op_dec = OP_LW;
        else if (load_store_info_i[4]) op_dec = OP_LBU;
        else if (load_store_info_i[3]) op_dec = OP_LHU;
        else if (load_store_info_i[2]) op_dec = OP_SB;
        else if (load_store_info_i[1]) op_dec = OP_SH;
        else                           op_dec = OP_SW;
    end

    always_comb begin
        store_dec = 1'b0;
        wstrb_dec = 4'b0000;
        wdata_dec = '0;
        case (op_dec)
            OP_SB: begin
                store_dec = 1'b1;
                wstrb_dec = 4'b0001 << off_in;
                wdata_dec = {4{store_data_i[7:0]}};
            end
            OP_SH: begin
                store_dec = 1'b1;
                wstrb_dec = off_in[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{store_data_i[15:0]}};
            end
            OP_SW: begin
                store_dec = 1'b1;
                wstrb_dec = 4'b1111;
                wdata_dec = store_data_i;
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    logic misalign_dec;
    always_comb begin
        misalign_dec = 1'b0;
        case (op_dec)
            OP_LH, OP_LHU, OP_SH: misalign_dec = off_in[0];
            OP_LW, OP_SW:         misalign_dec = |off_in;
            default:              misalign_dec = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LSU_MISALIGN_EN
                    state_d = misalign_dec ? S_ERR : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                if (dmem_gnt_i)   state_d = we_q ? S_DONE : S_WAIT;
                else if (flush_i) state_d = S_IDLE;
            end
            S_WAIT:  if (dmem_rvalid_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Extraction works on the captured offset so the response can arrive any cycle later.
    always_comb begin
        rshift   = dmem_rdata_i >> {off_q, 3'b000};
        half_sel = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_ext = dmem_rdata_i;
        case (op_q)
            OP_LB:   load_ext = {{24{rshift[7]}}, rshift[7:0]};
            OP_LBU:  load_ext = {24'h0, rshift[7:0]};
            OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {16'h0, half_sel};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LB;
            addr_q      <= '0;
            off_q       <= 2'b00;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            killed_q    <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q     <= op_dec;
                addr_q   <= {mem_addr_i[WIDTH-1:2], 2'b00};
                off_q    <= off_in;
                we_q     <= store_dec;
                wstrb_q  <= wstrb_dec;
                wdata_q  <= wdata_dec;
                killed_q <= 1'b0;
            end else if (flush_i && ((state_q == S_REQ && dmem_gnt_i) || state_q == S_WAIT)) begin
                killed_q <= 1'b1;
            end
            if (state_q == S_WAIT && dmem_rvalid_i && !killed_q && !flush_i)
                load_data_q <= load_ext;
        end
    end

    assign dmem_req_o   = (state_q == S_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wstrb_o = wstrb_q;
    assign dmem_wdata_o = wdata_q;
    assign lsu_stall_o  = start | (state_q == S_REQ) | (state_q == S_WAIT);
    assign lsu_done_o   = (state_q == S_DONE) & ~killed_q;
    assign load_data_o  = load_data_q;
`ifdef LSU_MISALIGN_EN
    assign misalign_o   = (state_q == S_ERR);
`else
    assign misalign_o   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, stalls, flushes, reset abandon, misalign/truncation.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  info;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        lsu_stall, lsu_done, misalign;
    logic [31:0] load_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid_i        (ex_valid),
        .load_store_info_i (info),
        .mem_addr_i        (mem_addr),
        .store_data_i      (store_data),
        .flush_i           (flush),
        .dmem_req_o        (dmem_req),
        .dmem_we_o         (dmem_we),
        .dmem_addr_o       (dmem_addr),
        .dmem_wstrb_o      (dmem_wstrb),
        .dmem_wdata_o      (dmem_wdata),
        .dmem_gnt_i        (dmem_gnt),
        .dmem_rvalid_i     (dmem_rvalid),
        .dmem_rdata_i      (dmem_rdata),
        .lsu_stall_o       (lsu_stall),
        .lsu_done_o        (lsu_done),
        .load_data_o       (load_data),
        .misalign_o        (misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit later.
    task automatic start_op(input logic [7:0] i, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ex_valid = 1'b1; info = i; mem_addr = a; store_data = d;
        #1 check("start_stall", {31'h0, lsu_stall}, 32'h1);
    endtask

    task automatic run_load(input string tag, input logic [7:0] i, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        start_op(i, a, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; dmem_gnt = 1'b1;
        #1 check({tag, "_req"}, {31'h0, dmem_req}, 32'h1);
        check({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
        check({tag, "_wstrb"}, {28'h0, dmem_wstrb}, 32'h0);
        check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
        #1 check({tag, "_wait_stall"}, {31'h0, lsu_stall}, 32'h1);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1 check({tag, "_done"}, {31'h0, lsu_done}, 32'h1);
        check({tag, "_data"}, load_data, exp);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; info = 8'h00; mem_addr = '0; store_data = '0;
        flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_stall", {31'h0, lsu_stall}, 32'h0);
        check("rst_done", {31'h0, lsu_done}, 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_ldata", load_data, 32'h0);
        check("rst_mis", {31'h0, misalign}, 32'h0);

        // sb with gnt in the same cycle as REQ
        start_op(8'h04, 32'h0000_1003, 32'h1234_5678);
        dmem_gnt = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00;
        #1 check("sb_req", {31'h0, dmem_req}, 32'h1);
        check("sb_addr", dmem_addr, 32'h0000_1000);
        check("sb_wstrb", {28'h0, dmem_wstrb}, 32'h8);
        check("sb_wdata", dmem_wdata, 32'h7878_7878);
        check("sb_we", {31'h0, dmem_we}, 32'h1);
        check("sb_done_early", {31'h0, lsu_done}, 32'h0);
        @(negedge clk);
        ex_valid = 1'b1; info = 8'h01; mem_addr = 32'h0000_1000; store_data = 32'hA5A5_0000;
        #1 check("sb_done", {31'h0, lsu_done}, 32'h1);
        check("done_no_accept", {31'h0, lsu_stall}, 32'h0);
        @(negedge clk);
        #1 check("sw_start_after_done", {31'h0, lsu_stall}, 32'h1);
        check("sw_idle_done", {31'h0, lsu_done}, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00;
        #1 check("sw_wstrb", {28'h0, dmem_wstrb}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'hA5A5_0000);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1 check("sw_done", {31'h0, lsu_done}, 32'h1);
        @(negedge clk);
        #1 check("sw_done_pulse", {31'h0, lsu_done}, 32'h0);

        run_load("lb",  8'h80, 32'h0000_2001, 32'h0000_80FF, 32'hFFFF_FF80);
        run_load("lbu", 8'h10, 32'h0000_2001, 32'h0000_80FF, 32'h0000_0080);
        run_load("lhu", 8'h08, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF);
        run_load("lh",  8'h40, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        run_load("lw",  8'h20, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D);
        run_load("multi", 8'h81, 32'h0000_2003, 32'h7F00_0000, 32'h0000_007F);

        // lw with gnt delayed 3 cycles and rvalid 2 cycles after gnt
        start_op(8'h20, 32'h0000_2008, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ex_valid = 1'b0; info = 8'h00; mem_addr = 32'hFFFF_FFFF;
            #1 check("dly_req", {31'h0, dmem_req}, 32'h1);
            check("dly_addr", dmem_addr, 32'h0000_2008);
            check("dly_stall", {31'h0, lsu_stall}, 32'h1);
        end
        @(negedge clk);
        dmem_gnt = 1'b1;
        #1 check("dly_req_gnt", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1 check("dly_wait_req", {31'h0, dmem_req}, 32'h0);
        check("dly_wait_stall", {31'h0, lsu_stall}, 32'h1);
        check("dly_wait_done", {31'h0, lsu_done}, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_BEEF;
        #1 check("dly_rv_stall", {31'h0, lsu_stall}, 32'h1);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1 check("dly_done", {31'h0, lsu_done}, 32'h1);
        check("dly_data", load_data, 32'h0BAD_BEEF);
        check("dly_done_stall", {31'h0, lsu_stall}, 32'h0);

        // flush in REQ before gnt
        start_op(8'h20, 32'h0000_2010, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; flush = 1'b1;
        #1 check("frq_req", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        #1 check("frq_idle_req", {31'h0, dmem_req}, 32'h0);
        check("frq_idle_stall", {31'h0, lsu_stall}, 32'h0);
        check("frq_done", {31'h0, lsu_done}, 32'h0);
        @(negedge clk);
        #1 check("frq_done2", {31'h0, lsu_done}, 32'h0);

        // flush in WAIT: response drained, no done, load data kept
        start_op(8'h20, 32'h0000_2014, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 check("fwt_stall", {31'h0, lsu_stall}, 32'h1);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1 check("fwt_done", {31'h0, lsu_done}, 32'h0);
        check("fwt_stall_drained", {31'h0, lsu_stall}, 32'h0);
        check("fwt_data", load_data, 32'h0BAD_BEEF);
        @(negedge clk);
        #1 check("fwt_data2", load_data, 32'h0BAD_BEEF);

        // gnt and flush together on a store: completes silently
        start_op(8'h01, 32'h0000_0040, 32'h0000_0001);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; dmem_gnt = 1'b1; flush = 1'b1;
        #1 check("fg_req", {31'h0, dmem_req}, 32'h1);
        @(negedge clk);
        dmem_gnt = 1'b0; flush = 1'b0;
        #1 check("fg_done", {31'h0, lsu_done}, 32'h0);
        check("fg_req_off", {31'h0, dmem_req}, 32'h0);

`ifdef LSU_MISALIGN_EN
        start_op(8'h20, 32'h0000_3002, 32'h0);
        check("mis_start_req", {31'h0, dmem_req}, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00;
        #1 check("mis_pulse", {31'h0, misalign}, 32'h1);
        check("mis_req", {31'h0, dmem_req}, 32'h0);
        check("mis_stall", {31'h0, lsu_stall}, 32'h0);
        @(negedge clk);
        #1 check("mis_pulse_end", {31'h0, misalign}, 32'h0);
        check("mis_req2", {31'h0, dmem_req}, 32'h0);
        check("mis_done", {31'h0, lsu_done}, 32'h0);
`else
        run_load("lw_trunc", 8'h20, 32'h0000_3002, 32'h1234_5678, 32'h1234_5678);
        check("trunc_mis", {31'h0, misalign}, 32'h0);
        start_op(8'h02, 32'h0000_1001, 32'h0000_BEEF);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; dmem_gnt = 1'b1;
        #1 check("sh_trunc_wstrb", {28'h0, dmem_wstrb}, 32'h3);
        check("sh_trunc_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_trunc_mis", {31'h0, misalign}, 32'h0);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1 check("sh_trunc_done", {31'h0, lsu_done}, 32'h1);
`endif

        // reset while waiting for a load response
        start_op(8'h20, 32'h0000_2020, 32'h0);
        @(negedge clk);
        ex_valid = 1'b0; info = 8'h00; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rw_req", {31'h0, dmem_req}, 32'h0);
        check("rw_stall", {31'h0, lsu_stall}, 32'h0);
        check("rw_addr", dmem_addr, 32'h0);
        check("rw_ldata", load_data, 32'h0);
        check("rw_done", {31'h0, lsu_done}, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1 check("rw_stray_done", {31'h0, lsu_done}, 32'h0);
        check("rw_stray_data", load_data, 32'h0);
        @(negedge clk);
        #1 check("rw_stray_done2", {31'h0, lsu_done}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
